// File: rtl/ant_dir_picker_pkg.sv
// Shared types and sizes for the pheromone-weighted ant direction picker.
package ant_dir_picker_pkg;

  localparam int unsigned NUM_DIRS     = 8;
  localparam int unsigned W_BITS       = 4;
  localparam int unsigned TOTAL_BITS   = 7;
  localparam int unsigned WEIGHTS_BITS = NUM_DIRS * W_BITS;

  typedef logic [2:0]        dir_t;
  typedef logic [W_BITS-1:0] weight_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_DRAW,
    S_WALK,
    S_DONE
  } picker_state_t;

  // Weight of direction k from the packed 8 x 4-bit weight word.
  function automatic weight_t weight_at(input logic [WEIGHTS_BITS-1:0] w, input dir_t k);
    return weight_t'(w >> {k, 2'b00});
  endfunction

endpackage

// File: rtl/ant_dir_picker_weight_sum8.sv
// Combinational sum of eight 4-bit weights into a 7-bit total (max 120).
module ant_dir_picker_weight_sum8
  import ant_dir_picker_pkg::*;
(
  input  logic [WEIGHTS_BITS-1:0] weights,
  output logic [TOTAL_BITS-1:0]   total
);

  always_comb begin
    total = '0;
    for (int unsigned k = 0; k < NUM_DIRS; k++) begin
      total = total + TOTAL_BITS'(weights[k*W_BITS +: W_BITS]);
    end
  end

endmodule

// File: rtl/ant_dir_picker.sv
// Turns the random_8 stream into one pheromone-weighted move direction per request,
// using rejection sampling with a fall-back to the current heading.
module ant_dir_picker
  import ant_dir_picker_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [WEIGHTS_BITS-1:0] weights,
  input  dir_t                    heading,
  input  logic [7:0]              rand_value,
  output logic                    busy,
  output logic                    done,
  output dir_t                    dir
);

  picker_state_t state, next_state;

  logic [WEIGHTS_BITS-1:0] w_q;
  dir_t                    head_q;
  logic [TOTAL_BITS-1:0]   total_q;
  logic [TOTAL_BITS-1:0]   sum_c;
  logic [TOTAL_BITS-1:0]   r_q;
  dir_t                    idx_q;
  logic [7:0]              acc_q;
  logic [3:0]              tries_q;
  dir_t                    pick_q;

  logic    accept_c;
  logic    last_try_c;
  logic    hit_c;
  weight_t cur_w_c;
  logic    unused_bits;

  ant_dir_picker_weight_sum8 u_sum (
    .weights (w_q),
    .total   (sum_c)
  );

  // Bit 7 is dropped so accepted draws are uniform over 0..total-1.
  assign unused_bits = rand_value[7];
  assign accept_c    = rand_value[6:0] < total_q;
  assign last_try_c  = tries_q == 4'(MAX_TRIES - 1);
  assign cur_w_c     = weight_at(w_q, idx_q);
  assign hit_c       = {1'b0, r_q} < (acc_q + 8'(cur_w_c));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_SUM;
      S_SUM:  next_state = S_DRAW;
      S_DRAW: begin
        if (total_q == '0)  next_state = S_DONE;
        else if (accept_c)  next_state = S_WALK;
        else if (last_try_c) next_state = S_DONE;
      end
      S_WALK: if (hit_c) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: request latch, total, draw/walk registers and the output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_q     <= '0;
      head_q  <= '0;
      total_q <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      tries_q <= '0;
      pick_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dir     <= '0;
    end else begin
      busy <= next_state != S_IDLE;
      done <= state == S_DONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            w_q     <= weights;
            head_q  <= heading;
            tries_q <= '0;
          end
        end
        S_SUM: total_q <= sum_c;
        S_DRAW: begin
          if (total_q == '0) begin
            pick_q <= rand_value[2:0];
          end else if (accept_c) begin
            r_q   <= rand_value[6:0];
            idx_q <= '0;
            acc_q <= '0;
          end else begin
            tries_q <= tries_q + 4'd1;
            if (last_try_c) pick_q <= head_q;
          end
        end
        S_WALK: begin
          if (hit_c) begin
            pick_q <= idx_q;
          end else begin
            acc_q <= acc_q + 8'(cur_w_c);
            idx_q <= idx_q + 3'd1;
          end
        end
        S_DONE: dir <= pick_q;
        default: ;
      endcase
    end
  end

endmodule
